// File: rtl/ram_frame_tx.sv
// Frame transmitter: reads a payload block from the shared 8-bit RAM and sends
// header, length, payload and XOR checksum through the UART byte handshake.
module ram_frame_tx #(
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter int         RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] src,
  input  logic [7:0] len,
  output logic [7:0] ram_addr,
  output logic       ram_rd_en,
  input  logic [7:0] ram_rdata,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE,
    SEND_HDR,
    WAIT_HDR,
    SEND_LEN,
    WAIT_LEN,
    FETCH,
    WAIT_RAM,
    SEND_DATA,
    WAIT_DATA,
    SEND_CSUM,
    WAIT_CSUM,
    FINISH
  } state_t;

  // RD_LATENCY is 1..3, so a 2-bit wait counter covers the whole range.
  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY);

  state_t     state_q, state_d;
  logic [7:0] ram_addr_q, ram_addr_d;
  logic [7:0] count_q, count_d;
  logic [7:0] csum_q, csum_d;
  logic [7:0] frame_len_q, frame_len_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [1:0] lat_q, lat_d;
  logic       ram_rd_en_q, ram_rd_en_d;
  logic       tx_dv_q, tx_dv_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    count_d     = count_q;
    csum_d      = csum_q;
    frame_len_d = frame_len_q;
    tx_byte_d   = tx_byte_q;
    lat_d       = lat_q;
    busy_d      = busy_q;
    ram_rd_en_d = 1'b0;
    tx_dv_d     = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ram_addr_d  = src;
          count_d     = len;
          frame_len_d = len;
          csum_d      = 8'h00;
          busy_d      = 1'b1;
          state_d     = SEND_HDR;
        end
      end
      SEND_HDR: begin
        tx_byte_d = HEADER;
        tx_dv_d   = 1'b1;
        state_d   = WAIT_HDR;
      end
      WAIT_HDR: begin
        if (tx_done) state_d = SEND_LEN;
      end
      SEND_LEN: begin
        tx_byte_d = frame_len_q;
        tx_dv_d   = 1'b1;
        csum_d    = csum_q ^ frame_len_q;
        state_d   = WAIT_LEN;
      end
      WAIT_LEN: begin
        if (tx_done) state_d = (count_q != 8'd0) ? FETCH : SEND_CSUM;
      end
      FETCH: begin
        ram_rd_en_d = 1'b1;
        lat_d       = 2'd0;
        state_d     = WAIT_RAM;
      end
      WAIT_RAM: begin
        // lat_q counts cycles since the strobe was on the RAM port.
        if (lat_q == LAT_LAST) begin
          tx_byte_d = ram_rdata;
          state_d   = SEND_DATA;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      SEND_DATA: begin
        tx_dv_d    = 1'b1;
        csum_d     = csum_q ^ tx_byte_q;
        ram_addr_d = ram_addr_q + 8'd1;
        count_d    = count_q - 8'd1;
        state_d    = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (tx_done) state_d = (count_q != 8'd0) ? FETCH : SEND_CSUM;
      end
      SEND_CSUM: begin
        tx_byte_d = csum_q;
        tx_dv_d   = 1'b1;
        state_d   = WAIT_CSUM;
      end
      WAIT_CSUM: begin
        if (tx_done) state_d = FINISH;
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ram_addr_q  <= 8'h00;
      count_q     <= 8'h00;
      csum_q      <= 8'h00;
      frame_len_q <= 8'h00;
      tx_byte_q   <= 8'h00;
      lat_q       <= 2'd0;
      ram_rd_en_q <= 1'b0;
      tx_dv_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      count_q     <= count_d;
      csum_q      <= csum_d;
      frame_len_q <= frame_len_d;
      tx_byte_q   <= tx_byte_d;
      lat_q       <= lat_d;
      ram_rd_en_q <= ram_rd_en_d;
      tx_dv_q     <= tx_dv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_rd_en = ram_rd_en_q;
  assign tx_dv     = tx_dv_q;
  assign tx_byte   = tx_byte_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/ram_frame_tx.md
Name: ram_frame_tx

Overview:
- Reader-side counterpart to the UART-RX-to-RAM capture path: streams a block of bytes out of the shared 8-bit RAM and drives the existing UART transmitter's valid/done byte handshake.
- Wraps the payload in a frame: header byte, length byte, payload, XOR checksum.
- Sits between the RAM controller and the UART transmitter. Replaces ad-hoc transmit sequencing in the top level with a deterministic, handshake-correct engine.

Parameters:
- HEADER, 8'hA5, first byte of every frame.
- RD_LATENCY, 1, cycles from ram_rd_en high to ram_rdata valid; legal range 1..3.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request to send a frame; sampled only in IDLE.
- src  input  8  RAM start address; captured on an accepted start.
- len  input  8  payload byte count, 0..255; captured on an accepted start.
- ram_addr  output  8  RAM read address.
- ram_rd_en  output  1  one-cycle read strobe.
- ram_rdata  input  8  RAM read data.
- tx_dv  output  1  one-cycle byte-valid pulse to the UART transmitter.
- tx_byte  output  8  byte to transmit; held stable until tx_done.
- tx_done  input  1  one-cycle pulse when the UART transmitter finishes a byte.
- busy  output  1  high from accepted start until the done pulse.
- done  output  1  one-cycle pulse after the checksum byte's tx_done.

Behaviour:
- Reset values:
  - ram_addr=0, ram_rd_en=0, tx_dv=0, tx_byte=0, busy=0, done=0.
  - Internal count=0, csum=0, state=IDLE.
- Reset has priority over every other input. Reset mid-frame aborts immediately: the next cycle is IDLE with outputs at reset values, and no further tx_dv is issued.
- States: IDLE, SEND_HDR, WAIT_HDR, SEND_LEN, WAIT_LEN, FETCH, WAIT_RAM, SEND_DATA, WAIT_DATA, SEND_CSUM, WAIT_CSUM, FINISH.
- IDLE:
  - On start: capture src into ram_addr, capture len into count, csum<=0, busy<=1, go to SEND_HDR.
  - start in any other state is ignored, with no effect on the frame in flight.
- SEND_x states (one cycle each):
  - tx_byte<=value, tx_dv<=1, go to the matching WAIT_x.
  - tx_dv is high for exactly one cycle.
- WAIT_x states:
  - Hold tx_byte; stay until tx_done=1.
  - tx_done outside a WAIT state is ignored.
- Frame sequencing:
  - SEND_HDR sends HEADER. WAIT_HDR goes to SEND_LEN.
  - SEND_LEN sends len and sets csum<=csum^len.
  - WAIT_LEN goes to FETCH if count!=0, else to SEND_CSUM.
- Payload loop:
  - FETCH: ram_rd_en<=1 for one cycle at the current ram_addr, go to WAIT_RAM.
  - WAIT_RAM: wait RD_LATENCY cycles after the strobe, then capture ram_rdata into tx_byte and go to SEND_DATA.
  - SEND_DATA: tx_dv<=1, csum<=csum^captured byte, ram_addr<=ram_addr+1 (mod 256, wrap 8'hFF->8'h00), count<=count-1.
  - WAIT_DATA on tx_done: go to FETCH if count!=0, else to SEND_CSUM.
- Checksum:
  - SEND_CSUM sends csum = XOR of the len byte and all payload bytes. HEADER is excluded.
  - WAIT_CSUM on tx_done goes to FINISH.
- FINISH: done<=1 for one cycle, busy<=0, go to IDLE. A start arriving in the FINISH cycle is ignored; start is accepted from the following cycle.
- Ordering guarantees:
  - ram_addr changes only in IDLE-accept and SEND_DATA, so it is stable throughout each RAM read.
  - A frame always contains len+3 bytes.
  - Exactly one tx_dv is issued per byte, and never while waiting on tx_done.

Test Plan:
- RAM[0x10..0x12]=0x01,0x02,0x03; start with src=0x10, len=3; tx_done returned 10 cycles after each tx_dv -> bytes A5,03,01,02,03,03. Then a single done pulse, busy low, ram_rd_en pulsed exactly 3 times.
- len=0, src=0x40 -> bytes A5,00,00; zero ram_rd_en pulses; done after the 3rd tx_done.
- src=0xFE, len=4, RAM[FE,FF,00,01]=0x11,0x22,0x33,0x44 -> ram_addr sequence FE,FF,00,01; payload as stored; checksum 0x04^0x11^0x22^0x33^0x44=0x40.
- start pulsed again during payload and in the FINISH cycle -> ignored; exactly one frame emitted. A start one cycle after done begins a new frame.
- rst asserted while in WAIT_DATA of byte 2 -> next cycle IDLE, all outputs at reset values. A later tx_done pulse produces no tx_dv, and a fresh start sends a complete frame.
- RD_LATENCY=3, len=2 -> tx_byte is captured 3 cycles after each ram_rd_en; bytes are correct and tx_byte is held stable from tx_dv until tx_done.
